// File: rtl/i2cm_rx_byte_ctrl.sv
// ---------------------------------------------------------------------------
// i2cm_rx_byte_ctrl
// Bit-level receive sequencer for the I2C master. Generates SCL for one read
// byte (8 data bits, MSB first) plus the ACK/NACK bit. It samples SDA at the
// end of the SCL-high quarter ph2, presenting it on o_data_ser with a
// one-cycle o_shift_en strobe for the downstream serial-to-parallel register.
//
// Each SCL bit is four quarters of SCL_QTR clocks:
//   ph0, ph1 : SCL pulled low
//   ph2, ph3 : SCL released (high)
//
// Handshake: i_rx_start is a request pulse, accepted only when the sequencer
// is idle (o_busy=0). Once accepted, o_busy stays high until the cycle after
// the one-cycle o_byte_done pulse. Requests seen while busy are dropped, not
// queued. i_stop_rel is likewise only honoured while idle.
//
// Optional build macro: I2CM_CLK_STRETCH_EN
//   This adds input i_scl_in. While SCL is released in ph2 and the pad still
//   reads low (a slave is stretching the clock), the quarter counter holds.
//   This delays sampling and all later timing.
//
// All outputs are registers so that an asynchronous reset releases the
// pads in the same cycle.
// ---------------------------------------------------------------------------
module i2cm_rx_byte_ctrl #(
   parameter int SCL_QTR = 25
) (
   input  logic clk,
   input  logic rst,
   input  logic i_rx_start,
   input  logic i_ack_en,
   input  logic i_stop_rel,
   input  logic i_sda_in,
`ifdef I2CM_CLK_STRETCH_EN
   input  logic i_scl_in,
`endif
   output logic o_scl_oe,
   output logic o_sda_oe,
   output logic o_shift_en,
   output logic o_data_ser,
   output logic o_busy,
   output logic o_byte_done
);

   localparam int QW = (SCL_QTR > 1) ? $clog2(SCL_QTR) : 1;
   localparam logic [QW-1:0] Q_LAST = QW'(SCL_QTR - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BIT  = 2'd1,
      S_ACK  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   // Current sequencer state and counters
   state_t          state;
   logic [QW-1:0]   qcnt;
   logic [1:0]      ph;
   logic [2:0]      bcnt;
   logic            scl_hold;
   logic            ack_bit;

   // Next-cycle values, computed combinationally and registered below
   state_t          nxt_state;
   logic [QW-1:0]   nxt_qcnt;
   logic [1:0]      nxt_ph;
   logic [2:0]      nxt_bcnt;
   logic            nxt_hold;
   logic            nxt_ack;

   // Next-cycle output values
   logic            scl_oe_d;
   logic            sda_oe_d;
   logic            shift_en_d;
   logic            data_ser_d;
   logic            busy_d;
   logic            byte_done_d;

   logic            stretch_hold;
   logic            in_bit_phase;

   // True while the sequencer is clocking a data or ACK bit
   assign in_bit_phase = (state == S_BIT) || (state == S_ACK);

`ifdef I2CM_CLK_STRETCH_EN
   // A slave holding SCL low during the released-high quarter freezes qcnt
   assign stretch_hold = in_bit_phase && (ph == 2'd2) && !i_scl_in;
`else
   assign stretch_hold = 1'b0;
`endif

   // Next-state and counter sequencing
   always_comb begin
      nxt_state = state;
      nxt_qcnt  = qcnt;
      nxt_ph    = ph;
      nxt_bcnt  = bcnt;
      nxt_hold  = scl_hold;
      nxt_ack   = ack_bit;
      case (state)
         S_IDLE: begin
            if (i_rx_start) begin
               // Start has priority over a simultaneous stop release
               nxt_state = S_BIT;
               nxt_qcnt  = '0;
               nxt_ph    = 2'd0;
               nxt_bcnt  = 3'd0;
               nxt_hold  = 1'b1;
               nxt_ack   = i_ack_en;
            end else if (i_stop_rel) begin
               nxt_hold  = 1'b0;
            end
         end
         S_BIT, S_ACK: begin
            if (stretch_hold) begin
               nxt_qcnt = qcnt;
            end else if (qcnt == Q_LAST) begin
               nxt_qcnt = '0;
               nxt_ph   = ph + 2'd1;
               if (ph == 2'd3) begin
                  if (state == S_BIT) begin
                     if (bcnt == 3'd7) begin
                        nxt_state = S_ACK;
                        nxt_bcnt  = 3'd0;
                     end else begin
                        nxt_bcnt  = bcnt + 3'd1;
                     end
                  end else begin
                     nxt_state = S_DONE;
                  end
               end
            end else begin
               nxt_qcnt = qcnt + QW'(1);
            end
         end
         S_DONE: begin
            nxt_state = S_IDLE;
         end
         default: begin
            nxt_state = S_IDLE;
         end
      endcase
   end

   // Output values for the cycle the next state will occupy
   always_comb begin
      scl_oe_d    = 1'b0;
      sda_oe_d    = 1'b0;
      shift_en_d  = 1'b0;
      data_ser_d  = o_data_ser;
      busy_d      = (nxt_state != S_IDLE);
      byte_done_d = (nxt_state == S_DONE);
      case (nxt_state)
         S_IDLE:  scl_oe_d = nxt_hold;
         S_BIT:   scl_oe_d = !nxt_ph[1];
         S_ACK:   scl_oe_d = !nxt_ph[1];
         S_DONE:  scl_oe_d = 1'b1;
         default: scl_oe_d = 1'b0;
      endcase
      sda_oe_d = (nxt_state == S_ACK) && nxt_ack;
      // Strobe once on entry to the last ph2 cycle; a stretch that parks
      // qcnt there must not produce a second strobe.
      shift_en_d = (nxt_state == S_BIT) && (nxt_ph == 2'd2) &&
                   (nxt_qcnt == Q_LAST) &&
                   !((state == S_BIT) && (ph == 2'd2) && (qcnt == Q_LAST));
      if (shift_en_d) begin
         data_ser_d = i_sda_in;
      end
   end

   // Sequencer state, counters and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_IDLE;
         qcnt        <= '0;
         ph          <= 2'd0;
         bcnt        <= 3'd0;
         scl_hold    <= 1'b0;
         ack_bit     <= 1'b0;
         o_scl_oe    <= 1'b0;
         o_sda_oe    <= 1'b0;
         o_shift_en  <= 1'b0;
         o_data_ser  <= 1'b0;
         o_busy      <= 1'b0;
         o_byte_done <= 1'b0;
      end else begin
         state       <= nxt_state;
         qcnt        <= nxt_qcnt;
         ph          <= nxt_ph;
         bcnt        <= nxt_bcnt;
         scl_hold    <= nxt_hold;
         ack_bit     <= nxt_ack;
         o_scl_oe    <= scl_oe_d;
         o_sda_oe    <= sda_oe_d;
         o_shift_en  <= shift_en_d;
         o_data_ser  <= data_ser_d;
         o_busy      <= busy_d;
         o_byte_done <= byte_done_d;
      end
   end

endmodule

// File: tb/tb_i2cm_rx_byte_ctrl.sv
// ---------------------------------------------------------------------------
// tb_i2cm_rx_byte_ctrl
// Directed bench for the receive sequencer with SCL_QTR=4.
// Stimulus pushes {kind, cycle, data} entries for every expected strobe and
// byte-done pulse. A negedge monitor pops and compares them, and also models
// the downstream s2p register.
// ---------------------------------------------------------------------------
module tb_i2cm_rx_byte_ctrl;

   localparam int Q = 4;
   localparam int W = 25;   // {kind[24], cycle[23:8], data[7:0]}

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic i_rx_start = 1'b0;
   logic i_ack_en = 1'b0;
   logic i_stop_rel = 1'b0;
   logic i_sda_in = 1'b0;
   logic i_scl_in = 1'b1;
   logic o_scl_oe, o_sda_oe, o_shift_en, o_data_ser, o_busy, o_byte_done;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   logic [7:0] s2p = 8'h00;
   logic [W-1:0] exp_q[$];

   i2cm_rx_byte_ctrl #(.SCL_QTR(Q)) dut (
      .clk(clk),
      .rst(rst),
      .i_rx_start(i_rx_start),
      .i_ack_en(i_ack_en),
      .i_stop_rel(i_stop_rel),
      .i_sda_in(i_sda_in),
`ifdef I2CM_CLK_STRETCH_EN
      .i_scl_in(i_scl_in),
`endif
      .o_scl_oe(o_scl_oe),
      .o_sda_oe(o_sda_oe),
      .o_shift_en(o_shift_en),
      .o_data_ser(o_data_ser),
      .o_busy(o_busy),
      .o_byte_done(o_byte_done)
   );

   // Clock and cycle counter
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   // Scoreboard monitor
   always @(negedge clk) begin
      if (!rst && (o_shift_en || o_byte_done)) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_event: shift=%0b done=%0b at cycle %0d", o_shift_en, o_byte_done, cyc);
         end else begin
            logic [W-1:0] e;
            e = exp_q.pop_front();
            chk("event_kind", {31'd0, o_byte_done}, {31'd0, e[24]});
            chk("event_cycle", cyc, {16'd0, e[23:8]});
            if (o_shift_en) begin
               chk("data_ser", {31'd0, o_data_ser}, {31'd0, e[0]});
               s2p = {s2p[6:0], o_data_ser};
            end else begin
               chk("s2p_byte", {24'd0, s2p}, {24'd0, e[7:0]});
            end
         end
      end
   end

   // One byte transfer with per-cycle SCL/SDA/busy checks.
   // ea/eb: offsets of extra (ignored) start pulses; rst_at: offset of a
   // mid-transfer reset (<0 for none); stretch: cycles SCL is held low from
   // the start of bit-0 ph2.
   task automatic run_byte(input logic [7:0] data, input logic ack,
                           input int ea, input int eb, input int rst_at,
                           input int stretch);
      int t0, last, ce, ph;
      logic exp_scl, exp_sda;
      @(negedge clk);
      t0 = cyc;
      s2p = 8'h00;
      for (int k = 0; k < 8; k++)
         exp_q.push_back({1'b0, 16'(t0 + 3*Q + 4*Q*k + stretch), 7'd0, data[7-k]});
      exp_q.push_back({1'b1, 16'(t0 + 36*Q + 1 + stretch), data});
      last = 36*Q + 1 + stretch;
      i_rx_start = 1'b1;
      i_ack_en = ack;
      i_sda_in = data[7];
      for (int c = 1; c <= last; c++) begin
         @(negedge clk);
         if (c > 2*Q + stretch) ce = c - stretch;
         else if (c > 2*Q) ce = 2*Q + 1;
         else ce = c;
         if (ce <= 36*Q) begin
            ph = ((ce - 1) % (4*Q)) / Q;
            exp_scl = (ph < 2);
         end else begin
            exp_scl = 1'b1;
         end
         exp_sda = ack && (ce >= 32*Q + 1) && (ce <= 36*Q);
         chk("busy", {31'd0, o_busy}, 32'd1);
         chk("scl_oe", {31'd0, o_scl_oe}, {31'd0, exp_scl});
         chk("sda_oe", {31'd0, o_sda_oe}, {31'd0, exp_sda});
         i_rx_start = (c == ea) || (c == eb);
         i_stop_rel = (c == 70);
         i_scl_in = !(stretch > 0 && c >= 2*Q + 1 && c <= 2*Q + stretch);
         if (ce <= 32*Q) i_sda_in = data[7 - ((ce - 1) / (4*Q))];
         else i_sda_in = 1'b1;
         if (c == rst_at) begin
            #2 rst = 1'b1;
            #1;
            chk("rst_scl_oe", {31'd0, o_scl_oe}, 32'd0);
            chk("rst_sda_oe", {31'd0, o_sda_oe}, 32'd0);
            chk("rst_busy", {31'd0, o_busy}, 32'd0);
            chk("rst_shift_en", {31'd0, o_shift_en}, 32'd0);
            exp_q.delete();
            i_rx_start = 1'b0;
            i_stop_rel = 1'b0;
            @(negedge clk);
            rst = 1'b0;
            return;
         end
      end
   endtask

   // Idle with SCL held, then release it with i_stop_rel
   task automatic idle_and_release();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         i_rx_start = 1'b0;
         chk("idle_scl_held", {31'd0, o_scl_oe}, 32'd1);
         chk("idle_busy", {31'd0, o_busy}, 32'd0);
         chk("idle_sda_oe", {31'd0, o_sda_oe}, 32'd0);
      end
      i_stop_rel = 1'b1;
      @(negedge clk);
      i_stop_rel = 1'b0;
      chk("scl_released", {31'd0, o_scl_oe}, 32'd0);
   endtask

   // Main sequence
   initial begin
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      // 1: reset and idle
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         chk("rst_idle_outs",
             {26'd0, o_scl_oe, o_sda_oe, o_shift_en, o_data_ser, o_busy, o_byte_done},
             32'd0);
      end
      // 2: 0xA5 with ACK
      run_byte(8'hA5, 1'b1, -1, -1, -1, 0);
      idle_and_release();
      // 3: 0x3C with NACK
      run_byte(8'h3C, 1'b0, -1, -1, -1, 0);
      idle_and_release();
      // 4: starts while busy and in DONE ignored, then back-to-back accept
      run_byte(8'h5A, 1'b1, 50, 36*Q + 1, -1, 0);
      run_byte(8'hC3, 1'b0, -1, -1, -1, 0);
      idle_and_release();
      // 5: reset mid-transfer, then a clean transfer
      run_byte(8'h96, 1'b1, -1, -1, 60, 0);
      @(negedge clk);
      chk("post_rst_scl", {31'd0, o_scl_oe}, 32'd0);
      run_byte(8'h81, 1'b1, -1, -1, -1, 0);
      idle_and_release();
`ifdef I2CM_CLK_STRETCH_EN
      // 6: clock stretch of 10 cycles in bit-0 ph2
      run_byte(8'h6B, 1'b1, -1, -1, -1, 10);
      idle_and_release();
`endif
      repeat (4) @(negedge clk);
      chk("queue_drained", exp_q.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Global time limit
   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish, checks=%0d", checks);
      $fatal(1);
   end

endmodule
